// File: rtl/sram_arb_pkg.sv
// Shared sizing and FSM encoding for the two-requester SRAM arbiter.
package sram_arb_pkg;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } arbState;

endpackage

// File: rtl/sram_rr_pick.sv
// Combinational 2-way round-robin picker; "last" names the requester granted most recently.
module sram_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);

  // A tie goes to whichever requester was not served last.
  assign gnt0 = req0 & (~req1 | last);
  assign gnt1 = req1 & (~req0 | ~last);

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for a single-write/single-read SRAM; walks the whole array
// to zero after reset, then serves one access per cycle in round-robin order.
module sram_arbiter #(
  parameter int AW    = sram_arb_pkg::AW,
  parameter int DW    = sram_arb_pkg::DW,
  parameter int DEPTH = sram_arb_pkg::DEPTH
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          sram_WE,
  output logic [AW-1:0] sram_WriteAddress,
  output logic [AW-1:0] sram_ReadAddress1,
  output logic [DW-1:0] sram_WriteBus,
  input  logic [DW-1:0] sram_ReadBus1,
  output logic          init_done
);

  import sram_arb_pkg::arbState;
  import sram_arb_pkg::CLEAR;
  import sram_arb_pkg::RUN;

  localparam logic [AW:0] ClrLast = (AW+1)'(DEPTH - 1);

  arbState       state, stateNext;
  logic [AW:0]   clrCnt, clrCntNext;
  logic          last, lastNext;
  logic          doneNext;
  logic          rdPend, rdPendNext;
  logic          rdPendId, rdPendIdNext;
  logic          weNext;
  logic [AW-1:0] waddrNext, raddrNext;
  logic [DW-1:0] wbusNext;

  logic          accept, acceptId, acceptWe;
  logic [AW-1:0] acceptAddr;
  logic [DW-1:0] acceptData;

  // Requests are masked until the clear walk has finished.
  sram_rr_pick picker (
    .req0 (req0 & init_done),
    .req1 (req1 & init_done),
    .last (last),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign accept     = gnt0 | gnt1;
  assign acceptId   = gnt1;
  assign acceptWe   = gnt1 ? we1    : we0;
  assign acceptAddr = gnt1 ? addr1  : addr0;
  assign acceptData = gnt1 ? wdata1 : wdata0;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    stateNext    = state;
    clrCntNext   = clrCnt;
    doneNext     = init_done;
    lastNext     = last;
    weNext       = 1'b0;
    waddrNext    = sram_WriteAddress;
    wbusNext     = sram_WriteBus;
    raddrNext    = sram_ReadAddress1;
    rdPendNext   = 1'b0;
    rdPendIdNext = rdPendId;

    unique case (state)
      CLEAR: begin
        weNext     = 1'b1;
        waddrNext  = clrCnt[AW-1:0];
        wbusNext   = '0;
        clrCntNext = clrCnt + 1'b1;
        if (clrCnt == ClrLast) begin
          stateNext = RUN;
          doneNext  = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          lastNext = acceptId;
          if (acceptWe) begin
            weNext    = 1'b1;
            waddrNext = acceptAddr;
            wbusNext  = acceptData;
          end else begin
            raddrNext    = acceptAddr;
            rdPendNext   = 1'b1;
            rdPendIdNext = acceptId;
          end
        end
      end
    endcase
  end

  // The SRAM array itself is zeroed by the CLEAR walk; reset only touches these control/data registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= CLEAR;
      clrCnt            <= '0;
      last              <= 1'b1;
      init_done         <= 1'b0;
      rdPend            <= 1'b0;
      rdPendId          <= 1'b0;
      sram_WE           <= 1'b0;
      sram_WriteAddress <= '0;
      sram_ReadAddress1 <= '0;
      sram_WriteBus     <= '0;
      rvalid0           <= 1'b0;
      rvalid1           <= 1'b0;
      rdata0            <= '0;
      rdata1            <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state             <= stateNext;
      clrCnt            <= clrCntNext;
      last              <= lastNext;
      init_done         <= doneNext;
      rdPend            <= rdPendNext;
      rdPendId          <= rdPendIdNext;
      sram_WE           <= weNext;
      sram_WriteAddress <= waddrNext;
      sram_ReadAddress1 <= raddrNext;
      sram_WriteBus     <= wbusNext;
      rvalid0           <= rdPend & ~rdPendId;
      rvalid1           <= rdPend & rdPendId;
      if (rdPend && !rdPendId) rdata0 <= sram_ReadBus1;
      if (rdPend &&  rdPendId) rdata1 <= sram_ReadBus1;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM: clear walk, table-driven
// RUN traffic, and hand-written reset corner sequences.
module tb_sram_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic          clock, reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          sram_WE, init_done;
  logic [AW-1:0] sram_WriteAddress, sram_ReadAddress1;
  logic [DW-1:0] sram_WriteBus, sram_ReadBus1;

  int nTests = 0;
  int nFail  = 0;

  sram_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clock             (clock),
    .reset             (reset),
    .req0              (req0),
    .we0               (we0),
    .addr0             (addr0),
    .wdata0            (wdata0),
    .gnt0              (gnt0),
    .rvalid0           (rvalid0),
    .rdata0            (rdata0),
    .req1              (req1),
    .we1               (we1),
    .addr1             (addr1),
    .wdata1            (wdata1),
    .gnt1              (gnt1),
    .rvalid1           (rvalid1),
    .rdata1            (rdata1),
    .sram_WE           (sram_WE),
    .sram_WriteAddress (sram_WriteAddress),
    .sram_ReadAddress1 (sram_ReadAddress1),
    .sram_WriteBus     (sram_WriteBus),
    .sram_ReadBus1     (sram_ReadBus1),
    .init_done         (init_done)
  );

  // Behavioural SRAM: write commits on the edge, read is combinational.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) if (sram_WE) mem[sram_WriteAddress] <= sram_WriteBus;
  assign sram_ReadBus1 = mem[sram_ReadAddress1];

  initial clock = 1'b0;
  always #50 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idleReqs();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
  endtask

  // Starts on the negedge of reset release; expects one clear write per edge.
  task automatic runClear(input string tag);
    int bad, doneAt, gntEarly, rvSeen;
    bad = 0; doneAt = -1; gntEarly = 0; rvSeen = 0;
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      if (!(sram_WE === 1'b1 && sram_WriteAddress === k[AW-1:0] && sram_WriteBus === '0)) bad++;
      if (init_done === 1'b1 && doneAt < 0) doneAt = k;
      if (init_done !== 1'b1 && (gnt0 | gnt1)) gntEarly++;
      if (rvalid0 | rvalid1) rvSeen++;
    end
    check({tag, " clear_walk_errors"}, 64'(bad), 64'd0);
    check({tag, " init_done_edge"}, 64'(doneAt), 64'd1023);
    check({tag, " grants_during_clear"}, 64'(gntEarly), 64'd0);
    check({tag, " rvalid_during_clear"}, 64'(rvSeen), 64'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, " sram_WE"}, 64'(sram_WE), 64'd0);
    check({tag, " waddr"}, 64'(sram_WriteAddress), 64'd0);
    check({tag, " raddr"}, 64'(sram_ReadAddress1), 64'd0);
    check({tag, " wbus"}, 64'(sram_WriteBus), 64'd0);
    check({tag, " rvalid"}, 64'({rvalid0, rvalid1}), 64'd0);
    check({tag, " rdata"}, {rdata0, rdata1}, 64'd0);
    check({tag, " init_done"}, 64'(init_done), 64'd0);
    check({tag, " gnt"}, 64'({gnt0, gnt1}), 64'd0);
  endtask

  typedef struct {
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          g0, g1, v0, v1, we;
    logic [DW-1:0] q0, q1;
  } vec_t;

  function automatic vec_t mk(input logic r0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic r1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic g0, g1, v0, v1, we,
                              input logic [DW-1:0] q0, q1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.we = we;
    v.q0 = q0; v.q1 = q1;
    return v;
  endfunction

  localparam logic [DW-1:0] BEEF = 32'hDEADBEEF;

  vec_t vecs [19];

  initial begin
    // Each row: inputs applied at negedge, outputs compared before the next edge.
    //            r0 w0 a0 d0      r1 w1 a1 d1      g0 g1 v0 v1 we q0    q1
    vecs[0]  = mk(1, 1, 5, BEEF,   0, 0, 0, 0,      1, 0, 0, 0, 0, 0,    0);
    vecs[1]  = mk(1, 0, 5, 0,      0, 0, 0, 0,      1, 0, 0, 0, 1, 0,    0);
    vecs[2]  = mk(0, 0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 0, 0, 0,    0);
    vecs[3]  = mk(0, 0, 0, 0,      0, 0, 0, 0,      0, 0, 1, 0, 0, BEEF, 0);
    vecs[4]  = mk(0, 0, 0, 0,      1, 1, 7, 32'h11, 0, 1, 0, 0, 0, BEEF, 0);
    vecs[5]  = mk(0, 0, 0, 0,      1, 0, 7, 0,      0, 1, 0, 0, 1, BEEF, 0);
    vecs[6]  = mk(1, 1, 7, 32'h22, 0, 0, 0, 0,      1, 0, 0, 0, 0, BEEF, 0);
    vecs[7]  = mk(0, 0, 0, 0,      1, 0, 7, 0,      0, 1, 0, 1, 1, BEEF, 32'h11);
    vecs[8]  = mk(0, 0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 0, 0, BEEF, 32'h11);
    vecs[9]  = mk(0, 0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 1, 0, BEEF, 32'h22);
    vecs[10] = mk(1, 0, 5, 0,      1, 0, 7, 0,      1, 0, 0, 0, 0, BEEF, 32'h22);
    vecs[11] = mk(1, 0, 5, 0,      1, 0, 7, 0,      0, 1, 0, 0, 0, BEEF, 32'h22);
    vecs[12] = mk(1, 0, 5, 0,      1, 0, 7, 0,      1, 0, 1, 0, 0, BEEF, 32'h22);
    vecs[13] = mk(1, 0, 5, 0,      1, 0, 7, 0,      0, 1, 0, 1, 0, BEEF, 32'h22);
    vecs[14] = mk(1, 0, 5, 0,      1, 0, 7, 0,      1, 0, 1, 0, 0, BEEF, 32'h22);
    vecs[15] = mk(1, 0, 5, 0,      1, 0, 7, 0,      0, 1, 0, 1, 0, BEEF, 32'h22);
    vecs[16] = mk(0, 0, 0, 0,      0, 0, 0, 0,      0, 0, 1, 0, 0, BEEF, 32'h22);
    vecs[17] = mk(0, 0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 1, 0, BEEF, 32'h22);
    vecs[18] = mk(0, 0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 0, 0, BEEF, 32'h22);

    idleReqs();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checkResetOutputs("por");

    // Hold a read request through the whole clear walk; it must wait for init_done.
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd3;
    reset = 1'b0;
    runClear("clr1");
    check("first_grant_at_init_done", 64'(gnt0), 64'd1);
    tick();
    req0 = 1'b0;
    check("first_read raddr", 64'(sram_ReadAddress1), 64'd3);
    check("first_read no_write", 64'(sram_WE), 64'd0);
    check("first_read rvalid_early", 64'(rvalid0), 64'd0);
    tick();
    check("first_read rvalid", 64'(rvalid0), 64'd1);
    check("first_read rdata_cleared", 64'(rdata0), 64'd0);
    tick();
    check("first_read rvalid_pulse_end", 64'(rvalid0), 64'd0);

    for (int i = 0; i < 19; i++) begin
      req0 = vecs[i].r0; we0 = vecs[i].w0; addr0 = vecs[i].a0; wdata0 = vecs[i].d0;
      req1 = vecs[i].r1; we1 = vecs[i].w1; addr1 = vecs[i].a1; wdata1 = vecs[i].d1;
      #1;
      check($sformatf("v%0d gnt", i), 64'({gnt0, gnt1}), 64'({vecs[i].g0, vecs[i].g1}));
      check($sformatf("v%0d rvalid", i), 64'({rvalid0, rvalid1}), 64'({vecs[i].v0, vecs[i].v1}));
      check($sformatf("v%0d sram_WE", i), 64'(sram_WE), 64'(vecs[i].we));
      check($sformatf("v%0d rdata", i), {rdata0, rdata1}, {vecs[i].q0, vecs[i].q1});
      tick();
    end
    idleReqs();

    // Reset one cycle after a read grant: the pending read must vanish.
    req1 = 1'b1; addr1 = 10'd5;
    #1;
    check("rst_rd grant", 64'(gnt1), 64'd1);
    tick();
    req1 = 1'b0;
    check("rst_rd raddr", 64'(sram_ReadAddress1), 64'd5);
    reset = 1'b1;
    #1;
    checkResetOutputs("rst_rd");
    tick();
    check("rst_rd rvalid_held1", 64'({rvalid0, rvalid1}), 64'd0);
    tick();
    check("rst_rd rvalid_held2", 64'({rvalid0, rvalid1}), 64'd0);
    reset = 1'b0;
    runClear("clr2");

    // Move the round-robin pointer to requester 0 before the next reset.
    req0 = 1'b1; addr0 = 10'd0;
    #1;
    check("pre_clr3 gnt0", 64'(gnt0), 64'd1);
    tick();
    req0 = 1'b0;
    repeat (3) tick();

    // Reset in the middle of the clear walk (clr_cnt = 300).
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (300) tick();
    check("mid_clear waddr", 64'(sram_WriteAddress), 64'd299);
    check("mid_clear init_done", 64'(init_done), 64'd0);
    #10;
    reset = 1'b1;
    #1;
    check("mid_clear rst sram_WE", 64'(sram_WE), 64'd0);
    check("mid_clear rst waddr", 64'(sram_WriteAddress), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    runClear("clr3");

    // Pointer must be back at 1, so requester 0 wins the first tie.
    req0 = 1'b1; req1 = 1'b1; addr0 = 10'd1; addr1 = 10'd2;
    #1;
    check("post_reset tie gnt", 64'({gnt0, gnt1}), 64'b10);
    idleReqs();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
